saida_display: RTL and testbench
================================

Name: saida_display

Overview:
- Output-side counterpart of the processor's switch-input path.
- When the processor executes an OUT instruction, this block captures the register value and converts it to decimal with a sequential double-dabble (one bit per clock).
- It then drives NUM_DIGITOS active-low seven-segment displays.
- The display holds the last completed value while a conversion is in progress, so it never flickers.

Parameters:
- DATA_WIDTH, 32, width of the value written by the processor.
- NUM_DIGITOS, 8, number of seven-segment digits driven (1..10).

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- escrever  input  1  OUT strobe; dado_saida is sampled on each rising edge where escrever=1.
- dado_saida  input  DATA_WIDTH  value to display.
- ocupado  output  1  high while a conversion is pending.
- estouro  output  1  last displayed value did not fit in NUM_DIGITOS.
- valor_exibido  output  DATA_WIDTH  raw value currently shown.
- segmentos  output  7*NUM_DIGITOS  digit i occupies bits [7i+6:7i]; bit order gfedcba; active low; digit 0 is least significant.

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - segmentos = all 1s (blank); valor_exibido = 0; estouro = 0; ocupado = 0.
  - FSM = OCIOSO; internal shift, BCD and counter registers = 0.
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- Capture:
  - Any edge with escrever=1, in any state: latch dado_saida into valor_pendente and clear the BCD register and counter.
  - Compute ovf_pend = (dado_saida >= 10^NUM_DIGITOS). The limit is a constant computed by a function at elaboration; the comparison is wide enough not to truncate.
  - Go to CONVERTE.
  - A write during CONVERTE or ATUALIZA restarts the conversion with the new value: last write wins, and the earlier value is never displayed.
- CONVERTE:
  - Each edge: add 3 to every BCD nibble >= 5, then shift {bcd, shift} left 1; counter++.
  - After DATA_WIDTH shifts, go to ATUALIZA.
  - The BCD register is 4*NUM_DIGITOS bits. High bits shifted out are discarded; this only happens when ovf_pend=1.
- ATUALIZA (one edge):
  - valor_exibido <= valor_pendente; estouro <= ovf_pend.
  - segmentos <= encoded digits; go to OCIOSO.
- Latency: write sampled at edge E0 → segmentos change at edge E0+DATA_WIDTH+1 (33 edges at default).
- ocupado:
  - Goes high from E0 and drops at the ATUALIZA edge.
  - Equals (state != OCIOSO).
- Encoding (active low):
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Dash = 0111111; blank = 1111111.
- Leading-zero blanking:
  - Every zero digit above the most significant nonzero digit is blank.
  - Digit 0 always shows, so value 0 displays as a single "0".
- Overflow (ovf_pend=1): all digits show dash.
- escrever held high continuously: the conversion restarts every edge and the display never updates. This is legal; ocupado stays 1.

Optional Feature:
- Macro: SAIDA_DISPLAY_SINAL_EN.
- Defined:
  - dado_saida is treated as two's complement.
  - Negative values: the magnitude (−x) is converted, and digit NUM_DIGITOS-1 shows a dash as the sign.
  - Overflow limit: magnitude >= 10^(NUM_DIGITOS-1).
  - The most negative value (e.g. 0x80000000) always sets estouro.
  - Positive values display as in unsigned mode, except that digit NUM_DIGITOS-1 is always blank.
- Undefined: unsigned interpretation exactly as above; no sign logic is synthesised.

Test Plan:
1. Reset: assert reset_n=0 mid-cycle → segmentos = all 1s immediately (asynchronous); ocupado=0, estouro=0, valor_exibido=0.
2. Basic write: write 1234 →
   - ocupado=1 for exactly 33 edges.
   - Then digits 0..3 = 0011001, 0110000, 0100100, 1111001; digits 4..7 = 1111111.
   - valor_exibido = 1234.
3. Zero and boundary:
   - Write 0 → digit 0 = 1000000, others blank.
   - Write 99999999 → all digits 0010000, estouro=0.
   - Write 100000000 → all digits 0111111, estouro=1.
4. Overwrite during conversion: write 5, then write 7 ten edges later →
   - Display never shows 5.
   - Digit 0 = 1111000 exactly 33 edges after the second write.
5. Reset mid-operation: pulse reset_n low during CONVERTE → outputs return to reset values and FSM = OCIOSO. A subsequent write of 42 displays normally.
6. With SAIDA_DISPLAY_SINAL_EN:
   - Write 0xFFFFFFD6 (−42) → digit 7 = 0111111, digits 0..1 = 0100100 and 0011001, others blank.
   - Write 0x80000000 → estouro=1.

Source files
------------

// File: rtl/saida_display.sv
// ---------------------------------------------------------------------------
// saida_display
//
// Output side of the processor's I/O path. When the processor executes an
// OUT instruction the value is captured, converted to decimal with a
// sequential double-dabble (one bit per clock) and then shown on NUM_DIGITOS
// active-low seven-segment displays. The previous value stays on the display
// until the new conversion has finished, so the digits never flicker.
//
// Parameters:
//   DATA_WIDTH   width of the value written by the processor (default 32)
//   NUM_DIGITOS  number of seven-segment digits driven, 1..10 (default 8)
//
// Ports:
//   clock          system clock, rising edge
//   reset_n        asynchronous, active-low reset
//   escrever       OUT strobe; dado_saida is sampled on each edge where high
//   dado_saida     value to display
//   ocupado        high while a conversion is pending
//   estouro        the displayed value did not fit in NUM_DIGITOS
//   valor_exibido  raw value currently shown
//   segmentos      digit i in bits [7i+6:7i], order gfedcba, active low,
//                  digit 0 is the least significant
//
// Optional feature (macro SAIDA_DISPLAY_SINAL_EN):
//   When defined, dado_saida is two's complement. Negative values show the
//   magnitude with a dash on the top digit as the sign; the top digit is
//   always blank for positive values. When undefined, no sign logic exists.
// ---------------------------------------------------------------------------
module saida_display #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_DIGITOS = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     escrever,
    input  logic [DATA_WIDTH-1:0]    dado_saida,
    output logic                     ocupado,
    output logic                     estouro,
    output logic [DATA_WIDTH-1:0]    valor_exibido,
    output logic [7*NUM_DIGITOS-1:0] segmentos
);

    localparam int BCD_W = 4 * NUM_DIGITOS;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    // 10^10 needs 34 bits, so the overflow comparison is done on at least
    // 40 bits to keep the limit from being truncated.
    localparam int CMP_W = (DATA_WIDTH > 40) ? DATA_WIDTH : 40;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] CONVERTE = 2'd1;
    localparam logic [1:0] ATUALIZA = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Power of ten evaluated at elaboration for the overflow limit.
    function automatic logic [CMP_W-1:0] pow10(input int n);
        logic [CMP_W-1:0] r;
        r = CMP_W'(1);
        for (int i = 0; i < n; i++) begin
            r = r * CMP_W'(10);
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

`ifdef SAIDA_DISPLAY_SINAL_EN
    localparam logic [CMP_W-1:0] LIMITE = pow10(NUM_DIGITOS - 1);
`else
    localparam logic [CMP_W-1:0] LIMITE = pow10(NUM_DIGITOS);
`endif

    logic [1:0]               state_q, state_d;
    logic [DATA_WIDTH-1:0]    valor_pendente_q, valor_pendente_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic [BCD_W-1:0]         bcd_q, bcd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_pend_q, ovf_pend_d;
    logic [DATA_WIDTH-1:0]    valor_exibido_q, valor_exibido_d;
    logic                     estouro_q, estouro_d;
    logic [7*NUM_DIGITOS-1:0] segmentos_q, segmentos_d;
`ifdef SAIDA_DISPLAY_SINAL_EN
    logic                     neg_pend_q, neg_pend_d;
    logic                     negativo;
`endif

    logic [DATA_WIDTH-1:0]    magnitude;
    logic                     ovf_calc;
    logic [BCD_W-1:0]         bcd_adj;
    logic [7*NUM_DIGITOS-1:0] seg_novos;
    logic                     visto;
    logic [3:0]               nibble;

    // Magnitude to convert and its overflow flag, computed at capture time.
    // In signed mode the most negative value has no positive counterpart and
    // is forced to overflow.
    always_comb begin
`ifdef SAIDA_DISPLAY_SINAL_EN
        negativo  = dado_saida[DATA_WIDTH-1];
        magnitude = negativo ? (~dado_saida + 1'b1) : dado_saida;
        ovf_calc  = (CMP_W'(magnitude) >= LIMITE) ||
                    (dado_saida == {1'b1, {(DATA_WIDTH-1){1'b0}}});
`else
        magnitude = dado_saida;
        ovf_calc  = (CMP_W'(magnitude) >= LIMITE);
`endif
    end

    // Double-dabble correction: every BCD nibble of 5 or more gets 3 added
    // before the shift so that it carries correctly into the next decade.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment image of the finished BCD value. Zeros above the most
    // significant nonzero digit are blanked; digit 0 always shows so that
    // zero appears as a single "0". Overflow replaces everything with dashes.
    always_comb begin
        seg_novos = '1;
        visto     = 1'b0;
        nibble    = 4'd0;
        for (int i = NUM_DIGITOS - 1; i >= 0; i--) begin
            nibble = bcd_q[4*i +: 4];
            if ((nibble != 4'd0) || (i == 0)) begin
                visto = 1'b1;
            end
            if (visto) begin
                seg_novos[7*i +: 7] = seg7(nibble);
            end
        end
`ifdef SAIDA_DISPLAY_SINAL_EN
        seg_novos[7*(NUM_DIGITOS-1) +: 7] = neg_pend_q ? SEG_DASH : SEG_BLANK;
`endif
        if (ovf_pend_q) begin
            for (int i = 0; i < NUM_DIGITOS; i++) begin
                seg_novos[7*i +: 7] = SEG_DASH;
            end
        end
    end

    // Next-state logic. A write has priority in every state so that the last
    // write always wins and a superseded value is never shown.
    always_comb begin
        state_d          = state_q;
        valor_pendente_d = valor_pendente_q;
        shift_d          = shift_q;
        bcd_d            = bcd_q;
        cnt_d            = cnt_q;
        ovf_pend_d       = ovf_pend_q;
        valor_exibido_d  = valor_exibido_q;
        estouro_d        = estouro_q;
        segmentos_d      = segmentos_q;
`ifdef SAIDA_DISPLAY_SINAL_EN
        neg_pend_d       = neg_pend_q;
`endif
        if (escrever) begin
            valor_pendente_d = dado_saida;
            shift_d          = magnitude;
            bcd_d            = '0;
            cnt_d            = '0;
            ovf_pend_d       = ovf_calc;
`ifdef SAIDA_DISPLAY_SINAL_EN
            neg_pend_d       = negativo;
`endif
            state_d          = CONVERTE;
        end else begin
            case (state_q)
                CONVERTE: begin
                    // The top BCD bit falls off only when the value overflows,
                    // in which case the digits are replaced by dashes anyway.
                    bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[DATA_WIDTH-1]};
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = ATUALIZA;
                    end
                end
                ATUALIZA: begin
                    valor_exibido_d = valor_pendente_q;
                    estouro_d       = ovf_pend_q;
                    segmentos_d     = seg_novos;
                    state_d         = OCIOSO;
                end
                default: begin
                    state_d = OCIOSO;
                end
            endcase
        end
    end

    // State registers; reset blanks the display.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= OCIOSO;
            valor_pendente_q <= '0;
            shift_q          <= '0;
            bcd_q            <= '0;
            cnt_q            <= '0;
            ovf_pend_q       <= 1'b0;
            valor_exibido_q  <= '0;
            estouro_q        <= 1'b0;
            segmentos_q      <= '1;
`ifdef SAIDA_DISPLAY_SINAL_EN
            neg_pend_q       <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            valor_pendente_q <= valor_pendente_d;
            shift_q          <= shift_d;
            bcd_q            <= bcd_d;
            cnt_q            <= cnt_d;
            ovf_pend_q       <= ovf_pend_d;
            valor_exibido_q  <= valor_exibido_d;
            estouro_q        <= estouro_d;
            segmentos_q      <= segmentos_d;
`ifdef SAIDA_DISPLAY_SINAL_EN
            neg_pend_q       <= neg_pend_d;
`endif
        end
    end

    assign ocupado       = (state_q != OCIOSO);
    assign estouro       = estouro_q;
    assign valor_exibido = valor_exibido_q;
    assign segmentos     = segmentos_q;

endmodule

// File: tb/tb_saida_display.sv
// ---------------------------------------------------------------------------
// tb_saida_display
//
// Self-checking bench for saida_display. Each write pushes the expected
// display image onto a scoreboard; when the conversion finishes the entry is
// popped and compared with the DUT outputs. Expected digits are produced by
// plain decimal division, independently of the double-dabble in the design.
// ---------------------------------------------------------------------------
module tb_saida_display;

    localparam int DW = 32;
    localparam int ND = 8;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            escrever;
    logic [DW-1:0]   dado_saida;
    logic            ocupado;
    logic            estouro;
    logic [DW-1:0]   valor_exibido;
    logic [7*ND-1:0] segmentos;

    typedef struct {
        logic [DW-1:0]   valor;
        logic [7*ND-1:0] segs;
        logic            ovf;
    } expect_t;

    expect_t         scoreboard[$];
    int              checks   = 0;
    int              failures = 0;
    logic [7*ND-1:0] shownSegs;
    logic            pending;

    saida_display #(.DATA_WIDTH(DW), .NUM_DIGITOS(ND)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .escrever     (escrever),
        .dado_saida   (dado_saida),
        .ocupado      (ocupado),
        .estouro      (estouro),
        .valor_exibido(valor_exibido),
        .segmentos    (segmentos)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [6:0] digitCode(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            default: s = 7'b0010000;
        endcase
        return s;
    endfunction

    // Reference display image for a written value.
    function automatic expect_t modelOf(input logic [DW-1:0] v);
        expect_t         e;
        longint unsigned mag;
        longint unsigned limit;
        longint unsigned m;
        int              numDigits;
        int              lastNonZero;
        int              dg[ND];
        bit              neg;
        bit              ovf;
`ifdef SAIDA_DISPLAY_SINAL_EN
        neg       = v[DW-1];
        mag       = neg ? ((64'd1 << DW) - 64'(v)) : 64'(v);
        numDigits = ND - 1;
`else
        neg       = 1'b0;
        mag       = 64'(v);
        numDigits = ND;
`endif
        limit = 1;
        for (int i = 0; i < numDigits; i++) limit = limit * 10;
        ovf = (mag >= limit);
`ifdef SAIDA_DISPLAY_SINAL_EN
        if (v == {1'b1, {(DW-1){1'b0}}}) ovf = 1'b1;
`endif
        e.valor = v;
        e.ovf   = ovf;
        e.segs  = '1;
        if (ovf) begin
            for (int i = 0; i < ND; i++) e.segs[7*i +: 7] = 7'b0111111;
        end else begin
            m           = mag;
            lastNonZero = 0;
            for (int i = 0; i < ND; i++) begin
                dg[i] = int'(m % 10);
                m     = m / 10;
                if (dg[i] != 0) lastNonZero = i;
            end
            for (int i = 0; i <= lastNonZero; i++) e.segs[7*i +: 7] = digitCode(dg[i]);
            if (neg) e.segs[7*(ND-1) +: 7] = 7'b0111111;
        end
        return e;
    endfunction

    // One-cycle OUT write; a write that lands on a pending conversion
    // replaces the superseded scoreboard entry. Called and returns at negedge.
    task automatic applyStimulus(input logic [DW-1:0] v);
        if (pending) scoreboard.delete(scoreboard.size() - 1);
        scoreboard.push_back(modelOf(v));
        pending    = 1'b1;
        dado_saida = v;
        escrever   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        escrever   = 1'b0;
    endtask

    // Waits for the running conversion, checking that the display holds,
    // then compares the new display against the scoreboard head.
    task automatic waitDisplay(input string tag);
        expect_t e;
        int      busy;
        busy = 0;
        while (ocupado && busy < 200) begin
            checkOutput({tag, "_hold"}, 64'(segmentos), 64'(shownSegs));
            busy++;
            @(negedge clock);
        end
        checkOutput({tag, "_busyEdges"}, 64'(busy), 64'(DW + 1));
        if (scoreboard.size() == 0) begin
            checkOutput({tag, "_scoreboard"}, 64'(scoreboard.size()), 64'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({tag, "_segs"}, 64'(segmentos), 64'(e.segs));
            checkOutput({tag, "_valor"}, 64'(valor_exibido), 64'(e.valor));
            checkOutput({tag, "_estouro"}, 64'(estouro), 64'(e.ovf));
            checkOutput({tag, "_idle"}, 64'(ocupado), 64'd0);
            shownSegs = e.segs;
        end
        pending = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_segs"}, 64'(segmentos), 64'(shownSegs));
        checkOutput({tag, "_ocupado"}, 64'(ocupado), 64'd0);
        checkOutput({tag, "_estouro"}, 64'(estouro), 64'd0);
        checkOutput({tag, "_valor"}, 64'(valor_exibido), 64'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        escrever   = 1'b0;
        dado_saida = '0;
        shownSegs  = '1;
        pending    = 1'b0;
        #12;
        checkReset("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        applyStimulus(32'd1234);
        waitDisplay("w1234");
        applyStimulus(32'd0);
        waitDisplay("w0");
        applyStimulus(32'd99999999);
        waitDisplay("wMax");
        applyStimulus(32'd100000000);
        waitDisplay("wOvf");

        // Overwrite ten edges after the first write; 5 must never appear.
        applyStimulus(32'd5);
        for (int k = 0; k < 9; k++) begin
            checkOutput("ovr_hold", 64'(segmentos), 64'(shownSegs));
            @(negedge clock);
        end
        applyStimulus(32'd7);
        waitDisplay("wOverwrite");

        // Strobe held high: every edge restarts, only the last value lands.
        for (int k = 0; k < 6; k++) begin
            dado_saida = DW'(100 + k);
            escrever   = 1'b1;
            @(posedge clock);
            @(negedge clock);
            checkOutput("held_busy", 64'(ocupado), 64'd1);
            checkOutput("held_hold", 64'(segmentos), 64'(shownSegs));
        end
        escrever = 1'b0;
        scoreboard.push_back(modelOf(DW'(105)));
        pending = 1'b1;
        waitDisplay("wHeld");

        for (int k = 0; k < 3; k++) begin
            applyStimulus(DW'($urandom_range(0, 99999999)));
            waitDisplay("wRand");
        end

        // Asynchronous reset in the middle of a conversion.
        applyStimulus(32'd1234);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        scoreboard.delete();
        pending   = 1'b0;
        shownSegs = '1;
        checkReset("midReset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        checkReset("afterReset");
        applyStimulus(32'd42);
        waitDisplay("w42");

`ifdef SAIDA_DISPLAY_SINAL_EN
        applyStimulus(32'hFFFFFFD6);
        waitDisplay("wNeg42");
        applyStimulus(32'h80000000);
        waitDisplay("wMinNeg");
        applyStimulus(32'd1234567);
        waitDisplay("wPos");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
